// File: rtl/regfile_sb_pkg.sv
// regfile_sb_pkg
// Shared CPU-level constants used by the pipeline and by the register file
// with scoreboard. Holds the default data width, register address width and
// the hardwired-zero-register setting.
package regfile_sb_pkg;

    localparam int CPU_DATA_W   = 32;
    localparam int CPU_ADDR_W   = 5;
    localparam bit CPU_ZERO_REG = 1'b1;

endpackage : regfile_sb_pkg

// File: rtl/rf_scoreboard.sv
// rf_scoreboard
// Tracks one busy bit per architectural register: set when an instruction
// that will produce the register issues, cleared when its result is written.
// Also keeps a registered popcount of the busy vector.
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   set_v, set_a        issue: mark register set_a busy
//   clr0_v/clr0_a       accepted write on port 0 (clears busy)
//   clr1_v/clr1_a       accepted write on port 1 (clears busy)
//   ra0, ra1            read addresses to report busy status for
//   rbusy0, rbusy1      register at raN busy and not being written this cycle
//   busy_cnt            number of busy registers (registered)
import regfile_sb_pkg::*;

module rf_scoreboard #(
    parameter int ADDR_W   = CPU_ADDR_W,
    parameter bit ZERO_REG = CPU_ZERO_REG
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              set_v,
    input  logic [ADDR_W-1:0] set_a,
    input  logic              clr0_v,
    input  logic [ADDR_W-1:0] clr0_a,
    input  logic              clr1_v,
    input  logic [ADDR_W-1:0] clr1_a,
    input  logic [ADDR_W-1:0] ra0,
    input  logic [ADDR_W-1:0] ra1,
    output logic              rbusy0,
    output logic              rbusy1,
    output logic [ADDR_W:0]   busy_cnt
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_next;
    logic [ADDR_W:0]  cnt_next;
    logic             set_ok;

    assign set_ok = set_v && !(ZERO_REG && (set_a == '0));

    // Clears are applied before the set so a new producer issued in the same
    // cycle as the old producer's writeback keeps the register busy.
    always_comb begin
        busy_next = busy;
        if (clr0_v) busy_next[clr0_a] = 1'b0;
        if (clr1_v) busy_next[clr1_a] = 1'b0;
        if (set_ok) busy_next[set_a] = 1'b1;
        if (rst)    busy_next = '0;
    end

    // Count is taken from the next-state vector so busy_cnt has no lag
    // relative to the busy bits themselves.
    always_comb begin
        cnt_next = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt_next = cnt_next + {{ADDR_W{1'b0}}, busy_next[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_next;
            busy_cnt <= cnt_next;
        end
    end

    // A value being written this cycle is bypassed to the reader, so it is
    // no longer waiting on its producer.
    always_comb begin
        rbusy0 = busy[ra0] && !((clr0_v && clr0_a == ra0) || (clr1_v && clr1_a == ra0));
        rbusy1 = busy[ra1] && !((clr0_v && clr0_a == ra1) || (clr1_v && clr1_a == ra1));
    end

endmodule : rf_scoreboard

// File: rtl/regfile_sb.sv
// regfile_sb
// Two-write, two-read register file with same-cycle write-through bypass and
// an attached busy-bit scoreboard for in-order issue hazard detection.
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   we0/wa0/wd0         write port 0 (lower priority)
//   we1/wa1/wd1         write port 1 (wins on same-address collision)
//   ra0/rd0, ra1/rd1    combinational read ports with bypass
//   rbusy0, rbusy1      register at raN still has a pending producer
//   iss_v, iss_a        issue marks register iss_a busy
//   busy_cnt            registered count of busy registers
import regfile_sb_pkg::*;

module regfile_sb #(
    parameter int DATA_W   = CPU_DATA_W,
    parameter int ADDR_W   = CPU_ADDR_W,
    parameter bit ZERO_REG = CPU_ZERO_REG
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we0,
    input  logic [ADDR_W-1:0] wa0,
    input  logic [DATA_W-1:0] wd0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] wa1,
    input  logic [DATA_W-1:0] wd1,
    input  logic [ADDR_W-1:0] ra0,
    output logic [DATA_W-1:0] rd0,
    input  logic [ADDR_W-1:0] ra1,
    output logic [DATA_W-1:0] rd1,
    output logic              rbusy0,
    output logic              rbusy1,
    input  logic              iss_v,
    input  logic [ADDR_W-1:0] iss_a,
    output logic [ADDR_W:0]   busy_cnt
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              wr0_ok;
    logic              wr1_ok;

    // Writes to register 0 are dropped when it is hardwired to zero.
    assign wr0_ok = we0 && !(ZERO_REG && (wa0 == '0));
    assign wr1_ok = we1 && !(ZERO_REG && (wa1 == '0));

    // Port 1 is written last so it overrides port 0 on the same address.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr0_ok) mem[wa0] <= wd0;
            if (wr1_ok) mem[wa1] <= wd1;
        end
    end

    // Bypass priority mirrors write priority; register 0 always reads zero.
    always_comb begin
        if (ZERO_REG && (ra0 == '0))      rd0 = '0;
        else if (we1 && (wa1 == ra0))     rd0 = wd1;
        else if (we0 && (wa0 == ra0))     rd0 = wd0;
        else                              rd0 = mem[ra0];
    end

    always_comb begin
        if (ZERO_REG && (ra1 == '0))      rd1 = '0;
        else if (we1 && (wa1 == ra1))     rd1 = wd1;
        else if (we0 && (wa0 == ra1))     rd1 = wd0;
        else                              rd1 = mem[ra1];
    end

    rf_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .set_v    (iss_v),
        .set_a    (iss_a),
        .clr0_v   (wr0_ok),
        .clr0_a   (wa0),
        .clr1_v   (wr1_ok),
        .clr1_a   (wa1),
        .ra0      (ra0),
        .ra1      (ra1),
        .rbusy0   (rbusy0),
        .rbusy1   (rbusy1),
        .busy_cnt (busy_cnt)
    );

endmodule : regfile_sb

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb
// Directed self-checking bench for regfile_sb: reset state, write-through
// bypass, dual-write priority, scoreboard set/clear/count, set-over-clear,
// register-zero suppression and mid-operation reset.
module tb_regfile_sb;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              we0, we1;
    logic [ADDR_W-1:0] wa0, wa1;
    logic [DATA_W-1:0] wd0, wd1;
    logic [ADDR_W-1:0] ra0, ra1;
    logic [DATA_W-1:0] rd0, rd1;
    logic              rbusy0, rbusy1;
    logic              iss_v;
    logic [ADDR_W-1:0] iss_a;
    logic [ADDR_W:0]   busy_cnt;

    int checks = 0;
    int errors = 0;

    regfile_sb #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (1'b1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .we0      (we0),
        .wa0      (wa0),
        .wd0      (wd0),
        .we1      (we1),
        .wa1      (wa1),
        .wd1      (wd1),
        .ra0      (ra0),
        .rd0      (rd0),
        .ra1      (ra1),
        .rd1      (rd1),
        .rbusy0   (rbusy0),
        .rbusy1   (rbusy1),
        .iss_v    (iss_v),
        .iss_a    (iss_a),
        .busy_cnt (busy_cnt)
    );

    always #5 clk = ~clk;

    // Advance past the next rising edge; inputs change 1 time unit later.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        we0 = 1'b0; wa0 = '0; wd0 = '0;
        we1 = 1'b0; wa1 = '0; wd1 = '0;
        iss_v = 1'b0; iss_a = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        ra0 = '0; ra1 = '0;
        next_cycle();
        next_cycle();
        rst = 1'b0;
        #1;
        checks++;
        if (busy_cnt !== 6'd0) begin
            errors++;
            $display("[TB] FAIL reset_busy_cnt got %0d expected 0", busy_cnt);
        end
        for (int a = 0; a < 32; a++) begin
            ra0 = a[ADDR_W-1:0];
            ra1 = 5'(31 - a);
            #1;
            checks++;
            if (rd0 !== 32'h0 || rbusy0 !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_read0 addr %0d got rd=%h busy=%b expected rd=0 busy=0", a, rd0, rbusy0);
            end
            checks++;
            if (rd1 !== 32'h0 || rbusy1 !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_read1 addr %0d got rd=%h busy=%b expected rd=0 busy=0", 31 - a, rd1, rbusy1);
            end
        end
    endtask

    task automatic test_bypass();
        next_cycle();
        we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEADBEEF; ra0 = 5'd5;
        #1;
        checks++;
        if (rd0 !== 32'hDEADBEEF) begin
            errors++;
            $display("[TB] FAIL bypass_same_cycle got %h expected deadbeef", rd0);
        end
        next_cycle();
        idle_inputs();
        #1;
        checks++;
        if (rd0 !== 32'hDEADBEEF) begin
            errors++;
            $display("[TB] FAIL bypass_next_cycle got %h expected deadbeef", rd0);
        end
    endtask

    task automatic test_dual_write();
        next_cycle();
        we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h11;
        we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h22;
        ra1 = 5'd7;
        #1;
        checks++;
        if (rd1 !== 32'h22) begin
            errors++;
            $display("[TB] FAIL dual_write_bypass got %h expected 00000022", rd1);
        end
        next_cycle();
        idle_inputs();
        ra0 = 5'd7;
        #1;
        checks++;
        if (rd0 !== 32'h22) begin
            errors++;
            $display("[TB] FAIL dual_write_stored got %h expected 00000022", rd0);
        end
    endtask

    task automatic test_busy();
        logic [ADDR_W:0] exp_cnt [3];
        logic [ADDR_W-1:0] iss_seq [3];
        exp_cnt = '{6'd1, 6'd2, 6'd2};
        iss_seq = '{5'd3, 5'd4, 5'd3};
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            idle_inputs();
            iss_v = 1'b1; iss_a = iss_seq[i];
            next_cycle();
            idle_inputs();
            #1;
            checks++;
            if (busy_cnt !== exp_cnt[i]) begin
                errors++;
                $display("[TB] FAIL busy_cnt_issue%0d got %0d expected %0d", i, busy_cnt, exp_cnt[i]);
            end
        end
        ra0 = 5'd3; ra1 = 5'd4;
        #1;
        checks++;
        if (rbusy0 !== 1'b1 || rbusy1 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL busy_bits_3_4 got %b%b expected 11", rbusy0, rbusy1);
        end
        we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h33;
        #1;
        checks++;
        if (rbusy0 !== 1'b0 || rd0 !== 32'h33) begin
            errors++;
            $display("[TB] FAIL write_cycle_rbusy3 got busy=%b rd=%h expected busy=0 rd=00000033", rbusy0, rd0);
        end
        checks++;
        if (rbusy1 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL write_cycle_rbusy4 got %b expected 1", rbusy1);
        end
        next_cycle();
        idle_inputs();
        #1;
        checks++;
        if (busy_cnt !== 6'd1 || rbusy0 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL after_write3 got cnt=%0d busy=%b expected cnt=1 busy=0", busy_cnt, rbusy0);
        end
        // Release register 4 through write port 1.
        we1 = 1'b1; wa1 = 5'd4; wd1 = 32'h44;
        next_cycle();
        idle_inputs();
        #1;
        checks++;
        if (busy_cnt !== 6'd0 || rbusy1 !== 1'b0 || rd1 !== 32'h44) begin
            errors++;
            $display("[TB] FAIL port1_clear got cnt=%0d busy=%b rd=%h expected cnt=0 busy=0 rd=00000044", busy_cnt, rbusy1, rd1);
        end
    endtask

    task automatic test_set_wins_and_zero();
        iss_v = 1'b1; iss_a = 5'd9;
        we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h99;
        ra0 = 5'd9;
        next_cycle();
        idle_inputs();
        #1;
        checks++;
        if (rbusy0 !== 1'b1 || busy_cnt !== 6'd1 || rd0 !== 32'h99) begin
            errors++;
            $display("[TB] FAIL set_wins_9 got busy=%b cnt=%0d rd=%h expected busy=1 cnt=1 rd=00000099", rbusy0, busy_cnt, rd0);
        end
        iss_v = 1'b1; iss_a = 5'd0;
        we0 = 1'b1; wa0 = 5'd0; wd0 = 32'hFF;
        ra0 = 5'd0;
        #1;
        checks++;
        if (rd0 !== 32'h0) begin
            errors++;
            $display("[TB] FAIL zero_reg_bypass got %h expected 0", rd0);
        end
        next_cycle();
        idle_inputs();
        #1;
        checks++;
        if (rd0 !== 32'h0 || rbusy0 !== 1'b0 || busy_cnt !== 6'd1) begin
            errors++;
            $display("[TB] FAIL zero_reg_after got rd=%h busy=%b cnt=%0d expected rd=0 busy=0 cnt=1", rd0, rbusy0, busy_cnt);
        end
    endtask

    task automatic test_reset_mid();
        logic [ADDR_W-1:0] regs [3];
        regs = '{5'd5, 5'd7, 5'd3};
        // Registers 5, 7, 3 hold nonzero data; together with 9 make four busy.
        for (int i = 0; i < 3; i++) begin
            iss_v = 1'b1; iss_a = regs[i];
            next_cycle();
        end
        idle_inputs();
        #1;
        checks++;
        if (busy_cnt !== 6'd4) begin
            errors++;
            $display("[TB] FAIL pre_reset_cnt got %0d expected 4", busy_cnt);
        end
        rst = 1'b1;
        we0 = 1'b1; wa0 = 5'd20; wd0 = 32'hABCD;
        iss_v = 1'b1; iss_a = 5'd21;
        ra0 = 5'd20; ra1 = 5'd5;
        #1;
        checks++;
        if (rd0 !== 32'hABCD) begin
            errors++;
            $display("[TB] FAIL reset_bypass got %h expected 0000abcd", rd0);
        end
        next_cycle();
        #1;
        checks++;
        if (busy_cnt !== 6'd0 || rbusy1 !== 1'b0 || rd1 !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_one_edge got cnt=%0d busy=%b rd=%h expected cnt=0 busy=0 rd=0", busy_cnt, rbusy1, rd1);
        end
        rst = 1'b0;
        idle_inputs();
        ra0 = 5'd20; ra1 = 5'd21;
        #1;
        checks++;
        if (rd0 !== 32'h0 || rbusy1 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_write_dropped got rd=%h busy21=%b expected rd=0 busy21=0", rd0, rbusy1);
        end
        ra0 = 5'd9; ra1 = 5'd7;
        #1;
        checks++;
        if (rd0 !== 32'h0 || rbusy0 !== 1'b0 || rd1 !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_cleared_9_7 got rd9=%h busy9=%b rd7=%h expected all 0", rd0, rbusy0, rd1);
        end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_dual_write();
        test_busy();
        test_set_wins_and_zero();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_regfile_sb
